// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// The datapath side is the master; the hazard unit is the slave.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    // Pipeline status flowing into the hazard unit
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic [4:0]       IF_ID_RegisterRn1;
    logic [4:0]       IF_ID_RegisterRm2;
    logic             EX_MEM_PCSrc;
    logic             EX_MEM_MemAccess;
    logic             dmem_ready;

    // Pipeline control and status flowing out of the hazard unit
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             Pipe_Hold;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
               EX_MEM_PCSrc, EX_MEM_MemAccess, dmem_ready,
        input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
               EX_MEM_Flush, Pipe_Hold, mem_error, stall_count, flush_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
               EX_MEM_PCSrc, EX_MEM_MemAccess, dmem_ready,
        output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
               EX_MEM_Flush, Pipe_Hold, mem_error, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// data-memory wait holds with a timeout watchdog, and saturating stall/flush counters.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [4:0]       XZR     = 5'd31;

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_error;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic w_mem_wait;
    logic w_load_use;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_bubble;
    logic w_flush;
    logic w_hold;

    assign w_mem_wait = bus.EX_MEM_MemAccess & ~bus.dmem_ready;

    assign w_load_use = bus.ID_EX_MemRead
                      & (bus.ID_EX_RegisterRd != XZR)
                      & ((bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRn1)
                       | (bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRm2));

    // RUN and WAIT share the same decode: a WAIT cycle that sees dmem_ready falls
    // through to the branch/load-use rules exactly like RUN.
    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_hold        = 1'b0;
        if (!reset) begin
            if (r_state == ST_ERROR || w_mem_wait) begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_hold        = 1'b1;
            end else if (bus.EX_MEM_PCSrc) begin
                w_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_bubble      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_error   <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!w_pc_write && r_stall_count != CNT_MAX) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush && r_flush_count != CNT_MAX) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end

            case (r_state)
                ST_RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (!w_mem_wait) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == TIMEOUT) begin
                        r_state     <= ST_ERROR;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ERROR: begin
                    r_state     <= ST_ERROR;
                    r_mem_error <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign bus.PC_Write     = w_pc_write;
    assign bus.IF_ID_Write  = w_if_id_write;
    assign bus.ID_EX_Bubble = w_bubble;
    assign bus.IF_ID_Flush  = w_flush;
    assign bus.ID_EX_Flush  = w_flush;
    assign bus.EX_MEM_Flush = w_flush;
    assign bus.Pipe_Hold    = w_hold;
    assign bus.mem_error    = r_mem_error;
    assign bus.stall_count  = r_stall_count;
    assign bus.flush_count  = r_flush_count;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus a randomized
// load-use/branch mix, with expected control vectors queued as stimulus is driven.
module tb_hazard_control_unit;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Control vector: {PC_Write, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Pipe_Hold}
    localparam logic [6:0] C_IDLE  = 7'b1100000;
    localparam logic [6:0] C_STALL = 7'b0010000;
    localparam logic [6:0] C_FLUSH = 7'b1101110;
    localparam logic [6:0] C_HOLD  = 7'b0000001;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ERROR = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_control_unit #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "time limit");
    end

    function automatic logic [6:0] ctrl();
        return {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble, bus.IF_ID_Flush,
                bus.ID_EX_Flush, bus.EX_MEM_Flush, bus.Pipe_Hold};
    endfunction

    // Applies one cycle of inputs just after a rising edge, queues the expected
    // control vector and returns at the falling edge for sampling.
    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rn1,
                         input logic [4:0] rm2, input logic pc, input logic macc,
                         input logic rdy, input logic [6:0] exp);
        bus.ID_EX_MemRead     = mr;
        bus.ID_EX_RegisterRd  = rd;
        bus.IF_ID_RegisterRn1 = rn1;
        bus.IF_ID_RegisterRm2 = rm2;
        bus.EX_MEM_PCSrc      = pc;
        bus.EX_MEM_MemAccess  = macc;
        bus.dmem_ready        = rdy;
        exp_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ID_EX_MemRead = 1'b0; bus.ID_EX_RegisterRd = 5'd0;
        bus.IF_ID_RegisterRn1 = 5'd0; bus.IF_ID_RegisterRm2 = 5'd0;
        bus.EX_MEM_PCSrc = 1'b0; bus.EX_MEM_MemAccess = 1'b0; bus.dmem_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got, exp;
        reset = 1'b1;
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, C_IDLE);
        got = ctrl(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", got, exp); end
        tick();
        reset = 1'b0;
        n_checks++;
        if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_RUN); end
        n_checks++;
        if (bus.mem_error !== 1'b0) begin n_fail++; $display("FAIL reset_mem_error: got %b expected 0", bus.mem_error); end
        n_checks++;
        if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.stall_count, bus.flush_count);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] got, exp;
        logic       mr_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] rd_t [5] = '{5'd5, 5'd0, 5'd9, 5'd9, 5'd4};
        logic [4:0] rn_t [5] = '{5'd5, 5'd0, 5'd1, 5'd9, 5'd5};
        logic [4:0] rm_t [5] = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd6};
        logic [6:0] ex_t [5] = '{C_STALL, C_IDLE, C_STALL, C_IDLE, C_IDLE};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(mr_t[i], rd_t[i], rn_t[i], rm_t[i], 1'b0, 1'b0, 1'b0, ex_t[i]);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL load_use_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
            if (i == 0) begin
                n_checks++;
                if (bus.stall_count !== 4'd1) begin n_fail++; $display("FAIL load_use_stall_count: got %0d expected 1", bus.stall_count); end
            end
        end
        n_checks++;
        if (bus.stall_count !== 4'd2) begin n_fail++; $display("FAIL load_use_stall_total: got %0d expected 2", bus.stall_count); end
    endtask

    task automatic test_xzr();
        logic [6:0] got, exp;
        do_reset();
        drive(1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, C_IDLE);
        got = ctrl(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL xzr_ctrl: got %b expected %b", got, exp); end
        tick();
        n_checks++;
        if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL xzr_stall_count: got %0d expected 0", bus.stall_count); end
    endtask

    task automatic test_branch_load_use();
        logic [6:0] got, exp;
        do_reset();
        drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, C_FLUSH);
        got = ctrl(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL branch_ctrl: got %b expected %b", got, exp); end
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE);
        got = ctrl(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL branch_after_ctrl: got %b expected %b", got, exp); end
        tick();
        n_checks++;
        if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'd0) begin
            n_fail++; $display("FAIL branch_counters: got flush %0d stall %0d expected 1/0", bus.flush_count, bus.stall_count);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] got, exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL mem_wait_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
            n_checks++;
            if (dbg_state !== S_WAIT) begin n_fail++; $display("FAIL mem_wait_state[%0d]: got %0d expected %0d", i, dbg_state, S_WAIT); end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, C_IDLE);
        got = ctrl(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mem_ready_ctrl: got %b expected %b", got, exp); end
        tick();
        n_checks++;
        if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL mem_ready_state: got %0d expected %0d", dbg_state, S_RUN); end
        n_checks++;
        if (bus.stall_count !== 4'd3) begin n_fail++; $display("FAIL mem_wait_stall_count: got %0d expected 3", bus.stall_count); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] got, exp;
        logic       pc_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       ma_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       ry_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [6:0] ex_t [5] = '{C_HOLD, C_STALL, C_HOLD, C_FLUSH, C_STALL};
        logic [1:0] st_t [5] = '{S_WAIT, S_RUN, S_WAIT, S_RUN, S_RUN};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd12, 5'd12, 5'd3, pc_t[i], ma_t[i], ry_t[i], ex_t[i]);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL b2b_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
            n_checks++;
            if (dbg_state !== st_t[i]) begin n_fail++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, dbg_state, st_t[i]); end
        end
        n_checks++;
        if (bus.stall_count !== 4'd4 || bus.flush_count !== 4'd1) begin
            n_fail++; $display("FAIL b2b_counters: got stall %0d flush %0d expected 4/1", bus.stall_count, bus.flush_count);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] got, exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL timeout_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
        end
        n_checks++;
        if (dbg_state !== S_ERROR) begin n_fail++; $display("FAIL timeout_state: got %0d expected %0d", dbg_state, S_ERROR); end
        n_checks++;
        if (bus.mem_error !== 1'b1) begin n_fail++; $display("FAIL timeout_mem_error: got %b expected 1", bus.mem_error); end
        // Memory recovers and a branch resolves, but ERROR must hold everything.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, C_HOLD);
        got = ctrl(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL error_ctrl: got %b expected %b", got, exp); end
        tick();
        n_checks++;
        if (bus.mem_error !== 1'b1 || bus.stall_count !== 4'd6 || bus.flush_count !== 4'd0) begin
            n_fail++; $display("FAIL error_sticky: got err %b stall %0d flush %0d expected 1/6/0",
                               bus.mem_error, bus.stall_count, bus.flush_count);
        end
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_IDLE);
        got = ctrl(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL error_reset_ctrl: got %b expected %b", got, exp); end
        tick();
        reset = 1'b0;
        n_checks++;
        if (dbg_state !== S_RUN || bus.mem_error !== 1'b0 || bus.stall_count !== 4'd0) begin
            n_fail++; $display("FAIL error_reset: got state %0d err %b stall %0d expected 0/0/0",
                               dbg_state, bus.mem_error, bus.stall_count);
        end
    endtask

    task automatic test_early_wait_state();
        logic [6:0] got, exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL wait4_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
        end
        n_checks++;
        if (dbg_state !== S_WAIT || bus.mem_error !== 1'b0) begin
            n_fail++; $display("FAIL wait4_state: got state %0d err %b expected 1/0", dbg_state, bus.mem_error);
        end
    endtask

    task automatic test_saturation();
        logic [6:0] got, exp;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, C_STALL);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sat_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sat_idle_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
            if (i == 13 || i >= 14) begin
                n_checks++;
                if (bus.stall_count !== ((i >= 14) ? 4'd15 : 4'd14)) begin
                    n_fail++; $display("FAIL sat_stall_count[%0d]: got %0d expected %0d", i, bus.stall_count, (i >= 14) ? 15 : 14);
                end
            end
        end
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, C_FLUSH);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sat_flush_ctrl[%0d]: got %b expected %b", i, got, exp); end
            tick();
        end
        n_checks++;
        if (bus.flush_count !== 4'd15 || bus.stall_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_flush_count: got flush %0d stall %0d expected 15/15", bus.flush_count, bus.stall_count);
        end
    endtask

    task automatic test_random();
        logic [6:0] got, exp, want;
        logic       mr, pc, lu;
        logic [4:0] rd, rn1, rm2;
        int         m_stall = 0;
        int         m_flush = 0;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            mr  = 1'($urandom_range(0, 1));
            pc  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            rn1 = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            rm2 = 5'($urandom_range(0, 3));
            lu  = mr && (rd != 5'd31) && (rd == rn1 || rd == rm2);
            want = pc ? C_FLUSH : (lu ? C_STALL : C_IDLE);
            if (pc && m_flush < 15) m_flush++;
            if (!pc && lu && m_stall < 15) m_stall++;
            drive(mr, rd, rn1, rm2, pc, 1'b0, 1'b0, want);
            got = ctrl(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got %b expected %b (mr=%b rd=%0d rn=%0d rm=%0d pc=%b)",
                                   i, got, exp, mr, rd, rn1, rm2, pc);
            end
            tick();
        end
        n_checks++;
        if (bus.stall_count !== 4'(m_stall) || bus.flush_count !== 4'(m_flush)) begin
            n_fail++; $display("FAIL rand_counters: got stall %0d flush %0d expected %0d/%0d",
                               bus.stall_count, bus.flush_count, m_stall, m_flush);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ID_EX_MemRead = 1'b0; bus.ID_EX_RegisterRd = 5'd0;
        bus.IF_ID_RegisterRn1 = 5'd0; bus.IF_ID_RegisterRm2 = 5'd0;
        bus.EX_MEM_PCSrc = 1'b0; bus.EX_MEM_MemAccess = 1'b0; bus.dmem_ready = 1'b0;
        tick();
        tick();
        test_reset();
        test_load_use();
        test_xzr();
        test_branch_load_use();
        test_mem_wait();
        test_back_to_back();
        test_early_wait_state();
        test_timeout();
        test_saturation();
        test_random();
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
